// File: rtl/i2c_pkg.sv
// Shared I2C definitions: protocol state names and bus-condition decoding,
// used by both the master and the register target.
package i2c_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_PTR,
    ST_PTR_ACK,
    ST_WDATA,
    ST_WDATA_ACK,
    ST_RDATA,
    ST_RACK
  } i2cState_t;

  typedef enum logic [1:0] {
    COND_NONE,
    COND_START,
    COND_STOP
  } i2cCond_t;

  // START/STOP are SDA edges while SCL is high; everything else is data.
  function automatic i2cCond_t busCond(input logic sclLevel,
                                       input logic sdaRise,
                                       input logic sdaFall);
    if (sclLevel && sdaFall) return COND_START;
    if (sclLevel && sdaRise) return COND_STOP;
    return COND_NONE;
  endfunction

endpackage

// File: rtl/i2c_line_sync.sv
// Two-flop synchronizer plus a history flop for one open-drain bus line.
// Flops reset to 1 so an idle (pulled-up) line produces no edge after reset.
module i2c_line_sync (
  input  logic clk,
  input  logic reset,
  input  logic rawLine,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [1:0] syncReg;
  logic       histReg;

  always_ff @(posedge clk) begin
    if (reset) begin
      syncReg <= 2'b11;
      histReg <= 1'b1;
    end else begin
      syncReg <= {syncReg[0], rawLine};
      histReg <= syncReg[1];
    end
  end

  assign level = syncReg[1];
  assign rise  = syncReg[1] & ~histReg;
  assign fall  = ~syncReg[1] & histReg;

endmodule

// File: rtl/i2c_reg_target.sv
// I2C target with a small register file: pointer write, burst write and
// burst read with auto-increment, plus a host-side read/notify port.
module i2c_reg_target
  import i2c_pkg::*;
#(
  parameter logic [6:0] ADDR  = 7'h4A,
  parameter int         NREGS = 4,
  localparam int        AW    = $clog2(NREGS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          scl,
  inout  wire           sda,
  input  logic [AW-1:0] host_addr,
  output logic [7:0]    host_rdata,
  output logic          wr_strobe,
  output logic [AW-1:0] wr_index,
  output logic [7:0]    wr_value,
  output logic          busy
);

  logic sclLevel, sclRise, sclFall;
  logic sdaLevel, sdaRise, sdaFall;

  i2c_line_sync sclSync (
    .clk(clk), .reset(reset), .rawLine(scl),
    .level(sclLevel), .rise(sclRise), .fall(sclFall)
  );

  i2c_line_sync sdaSync (
    .clk(clk), .reset(reset), .rawLine(sda),
    .level(sdaLevel), .rise(sdaRise), .fall(sdaFall)
  );

  i2cState_t     stateReg, stateNext;
  logic [2:0]    bitCntReg, bitCntNext;
  logic [7:0]    shiftReg, shiftNext;
  logic [AW-1:0] ptrReg, ptrNext;
  logic          sdaLowReg, sdaLowNext;
  logic          busyReg, busyNext;
  logic          firstWrReg, firstWrNext;
  logic          rwReg, rwNext;
  logic          ackSeenReg, ackSeenNext;
  logic          wrStrobeReg, wrStrobeNext;
  logic [AW-1:0] wrIndexReg, wrIndexNext;
  logic [7:0]    wrValueReg, wrValueNext;
  logic          regWe;
  logic [7:0]    regs [NREGS];

  logic [7:0] rxByte;
  logic       lastBit;
  i2cCond_t   cond;

  assign rxByte  = {shiftReg[6:0], sdaLevel};
  assign lastBit = (bitCntReg == 3'd7);
  assign cond    = busCond(sclLevel, sdaRise, sdaFall);

  always_ff @(posedge clk) begin
    if (reset) begin
      stateReg    <= ST_IDLE;
      bitCntReg   <= '0;
      shiftReg    <= '0;
      ptrReg      <= '0;
      sdaLowReg   <= 1'b0;
      busyReg     <= 1'b0;
      firstWrReg  <= 1'b0;
      rwReg       <= 1'b0;
      ackSeenReg  <= 1'b0;
      wrStrobeReg <= 1'b0;
      wrIndexReg  <= '0;
      wrValueReg  <= '0;
    end else begin
      stateReg    <= stateNext;
      bitCntReg   <= bitCntNext;
      shiftReg    <= shiftNext;
      ptrReg      <= ptrNext;
      sdaLowReg   <= sdaLowNext;
      busyReg     <= busyNext;
      firstWrReg  <= firstWrNext;
      rwReg       <= rwNext;
      ackSeenReg  <= ackSeenNext;
      wrStrobeReg <= wrStrobeNext;
      wrIndexReg  <= wrIndexNext;
      wrValueReg  <= wrValueNext;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (regWe) begin
      regs[ptrReg] <= rxByte;
    end
  end

  always_comb begin
    stateNext    = stateReg;
    bitCntNext   = bitCntReg;
    shiftNext    = shiftReg;
    ptrNext      = ptrReg;
    sdaLowNext   = sdaLowReg;
    busyNext     = busyReg;
    firstWrNext  = firstWrReg;
    rwNext       = rwReg;
    ackSeenNext  = ackSeenReg;
    wrStrobeNext = 1'b0;
    wrIndexNext  = wrIndexReg;
    wrValueNext  = wrValueReg;
    regWe        = 1'b0;

    if (cond == COND_START) begin
      stateNext   = ST_ADDR;
      bitCntNext  = '0;
      sdaLowNext  = 1'b0;
      firstWrNext = 1'b1;
      ackSeenNext = 1'b0;
    end else if (cond == COND_STOP) begin
      stateNext   = ST_IDLE;
      bitCntNext  = '0;
      sdaLowNext  = 1'b0;
      busyNext    = 1'b0;
      ackSeenNext = 1'b0;
    end else if (sclRise) begin
      case (stateReg)
        ST_ADDR, ST_PTR, ST_WDATA: begin
          shiftNext  = rxByte;
          bitCntNext = bitCntReg + 3'd1;
          if (lastBit) begin
            case (stateReg)
              ST_ADDR: begin
                if (rxByte[7:1] == ADDR) begin
                  stateNext = ST_ADDR_ACK;
                  rwNext    = rxByte[0];
                  busyNext  = 1'b1;
                end else begin
                  stateNext = ST_IDLE;
                  busyNext  = 1'b0;
                end
              end
              ST_PTR: begin
                ptrNext     = rxByte[AW-1:0];
                firstWrNext = 1'b0;
                stateNext   = ST_PTR_ACK;
              end
              default: begin
                regWe        = 1'b1;
                wrStrobeNext = 1'b1;
                wrIndexNext  = ptrReg;
                wrValueNext  = rxByte;
                ptrNext      = ptrReg + 1'b1;
                stateNext    = ST_WDATA_ACK;
              end
            endcase
          end
        end
        ST_RDATA: begin
          bitCntNext = bitCntReg + 3'd1;
          if (lastBit) begin
            stateNext   = ST_RACK;
            ackSeenNext = 1'b0;
          end
        end
        ST_RACK: begin
          if (!sdaLevel) begin
            ptrNext     = ptrReg + 1'b1;
            ackSeenNext = 1'b1;
          end else begin
            stateNext  = ST_IDLE;
            sdaLowNext = 1'b0;
          end
        end
        default: ;
      endcase
    end else if (sclFall) begin
      case (stateReg)
        // The first fall in an ACK state starts the ACK, the second ends it.
        ST_ADDR_ACK, ST_PTR_ACK, ST_WDATA_ACK: begin
          if (!sdaLowReg) begin
            sdaLowNext = 1'b1;
          end else begin
            sdaLowNext = 1'b0;
            bitCntNext = '0;
            if (stateReg == ST_ADDR_ACK && rwReg) begin
              stateNext  = ST_RDATA;
              shiftNext  = regs[ptrReg];
              sdaLowNext = ~regs[ptrReg][7];
            end else if (stateReg == ST_ADDR_ACK && firstWrReg) begin
              stateNext = ST_PTR;
            end else begin
              stateNext = ST_WDATA;
            end
          end
        end
        ST_RDATA: begin
          shiftNext  = {shiftReg[6:0], 1'b0};
          sdaLowNext = ~shiftReg[6];
        end
        ST_RACK: begin
          if (ackSeenReg) begin
            stateNext   = ST_RDATA;
            bitCntNext  = '0;
            ackSeenNext = 1'b0;
            shiftNext   = regs[ptrReg];
            sdaLowNext  = ~regs[ptrReg][7];
          end else begin
            sdaLowNext = 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign sda        = sdaLowReg ? 1'b0 : 1'bz;
  assign host_rdata = regs[host_addr];
  assign wr_strobe  = wrStrobeReg;
  assign wr_index   = wrIndexReg;
  assign wr_value   = wrValueReg;
  assign busy       = busyReg;

endmodule

// File: tb/tb_i2c_reg_target.sv
// Directed bench: bit-banged I2C master, transaction-level target model and
// a per-cycle commit checker.
module tb_i2c_reg_target;

  localparam int Q = 4;  // clk cycles per quarter SCL period

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       scl = 1'b1;
  logic       mLow = 1'b0;
  logic [1:0] host_addr = 2'd0;
  logic [7:0] host_rdata;
  logic       wr_strobe;
  logic [1:0] wr_index;
  logic [7:0] wr_value;
  logic       busy;
  wire        sda;

  pullup (sda);
  assign sda = mLow ? 1'b0 : 1'bz;

  always #5 clk = ~clk;

  i2c_reg_target #(.ADDR(7'h4A), .NREGS(4)) dut (
    .clk(clk), .reset(reset), .scl(scl), .sda(sda),
    .host_addr(host_addr), .host_rdata(host_rdata),
    .wr_strobe(wr_strobe), .wr_index(wr_index), .wr_value(wr_value),
    .busy(busy)
  );

  int compared = 0;
  int mismatched = 0;

  task automatic check(input string name, input int act, input int exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  // Transaction-level model of the target
  typedef struct { int idx; int val; } commit_t;
  commit_t    expQ[$];
  commit_t    cmpC;
  logic [7:0] mRegs [4];
  int         mPtr = 0;
  bit         mAddressed = 0, mRw = 0, mFirstWr = 0, mExpAddr = 0, mBusy = 0;
  bit         quietExp = 0;

  task automatic modelReset();
    for (int i = 0; i < 4; i++) mRegs[i] = 8'h00;
    mPtr = 0; mAddressed = 0; mRw = 0; mFirstWr = 0; mExpAddr = 0; mBusy = 0;
    expQ.delete();
  endtask

  // Every commit the DUT announces must be the next one the model predicted.
  always @(negedge clk) begin
    if (!reset) begin
      if (wr_strobe) begin
        if (expQ.size() == 0) begin
          check("unexpected_wr_strobe", 1, 0);
        end else begin
          cmpC = expQ.pop_front();
          check("wr_index", int'(wr_index), cmpC.idx);
          check("wr_value", int'(wr_value), cmpC.val);
        end
      end
      if (quietExp && !mLow) check("quiet_sda", int'(sda), 1);
    end
  end

  task automatic waitCyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bitCycle(input bit b, output bit sampled);
    mLow = ~b;
    waitCyc(Q);
    scl = 1'b1;
    waitCyc(Q);
    sampled = sda;
    waitCyc(Q);
    scl = 1'b0;
    waitCyc(Q);
  endtask

  task automatic mStart();
    if (scl) begin
      mLow = 1'b1;
      waitCyc(Q);
    end else begin
      mLow = 1'b0;
      waitCyc(Q);
      scl = 1'b1;
      waitCyc(Q);
      mLow = 1'b1;
      waitCyc(Q);
    end
    scl = 1'b0;
    waitCyc(Q);
    mExpAddr = 1; mFirstWr = 1;
    $display("START");
  endtask

  task automatic mStop();
    mLow = 1'b1;
    waitCyc(Q);
    scl = 1'b1;
    waitCyc(Q);
    mLow = 1'b0;
    waitCyc(2 * Q);
    mBusy = 0; mAddressed = 0; mExpAddr = 0;
    $display("STOP");
  endtask

  task automatic sendBits(input logic [7:0] b, input int n);
    bit got;
    for (int i = 7; i > 7 - n; i--) bitCycle(b[i], got);
  endtask

  task automatic sendByte(input logic [7:0] b);
    bit expAck, got;
    if (mExpAddr) begin
      mExpAddr   = 0;
      mAddressed = (b[7:1] == 7'h4A);
      mRw        = b[0];
      mBusy      = mAddressed;
      expAck     = mAddressed;
    end else if (mAddressed && !mRw) begin
      expAck = 1;
      if (mFirstWr) begin
        mPtr = int'(b) % 4;
        mFirstWr = 0;
      end else begin
        mRegs[mPtr] = b;
        expQ.push_back('{mPtr, int'(b)});
        mPtr = (mPtr + 1) % 4;
      end
    end else begin
      expAck = 0;
    end
    for (int i = 7; i >= 0; i--) bitCycle(b[i], got);
    bitCycle(1'b1, got);
    $display("write byte 0x%02h  ack=%0d", b, !got);
    check("ack_bit", int'(got), int'(!expAck));
  endtask

  task automatic readByte(input bit ack, output logic [7:0] v);
    logic [7:0] exp;
    bit got;
    exp = (mAddressed && mRw) ? mRegs[mPtr] : 8'hFF;
    v = 8'h00;
    for (int i = 0; i < 8; i++) begin
      bitCycle(1'b1, got);
      v = {v[6:0], got};
    end
    bitCycle(!ack, got);
    if (mAddressed && mRw) begin
      if (ack) mPtr = (mPtr + 1) % 4;
      else mAddressed = 0;
    end
    $display("read byte 0x%02h  master_ack=%0d", v, ack);
    check("read_data", int'(v), int'(exp));
  endtask

  task automatic checkState(input string tag);
    for (int a = 0; a < 4; a++) begin
      host_addr = 2'(a);
      #1;
      check({tag, "_host_rdata"}, int'(host_rdata), int'(mRegs[a]));
    end
    check({tag, "_busy"}, int'(busy), int'(mBusy));
    check({tag, "_pending_commits"}, expQ.size(), 0);
  endtask

  task automatic hostRead(input int a, output logic [7:0] v);
    host_addr = 2'(a);
    #1;
    v = host_rdata;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] rd, rd2;
    bit got;
    modelReset();
    waitCyc(4);
    reset = 1'b0;
    waitCyc(2);

    // Reset values
    check("reset_busy", int'(busy), 0);
    check("reset_wr_strobe", int'(wr_strobe), 0);
    check("reset_wr_index", int'(wr_index), 0);
    check("reset_wr_value", int'(wr_value), 0);
    check("reset_sda", int'(sda), 1);
    for (int a = 0; a < 4; a++) begin
      hostRead(a, rd);
      check("reset_reg", int'(rd), 0);
    end

    // Write burst
    mStart();
    sendByte(8'h94);
    check("busy_after_match", int'(busy), 1);
    sendByte(8'h02);
    sendByte(8'hA6);
    sendByte(8'hE4);
    mStop();
    check("burst_wr_index", int'(wr_index), 3);
    check("burst_wr_value", int'(wr_value), 8'hE4);
    hostRead(2, rd);
    check("burst_reg2", int'(rd), 8'hA6);
    checkState("burst");

    // Read after pointer set, with repeated START
    mStart();
    sendByte(8'h94);
    sendByte(8'h02);
    mStart();
    sendByte(8'h95);
    readByte(1'b1, rd);
    readByte(1'b0, rd2);
    check("read_first_literal", int'(rd), 8'hA6);
    check("read_second_literal", int'(rd2), 8'hE4);
    check("released_after_nack", int'(sda), 1);
    bitCycle(1'b1, got);
    check("no_drive_after_nack", int'(got), 1);
    mStop();
    checkState("read");

    // Pointer persisted at 3
    mStart();
    sendByte(8'h95);
    readByte(1'b0, rd);
    mStop();
    check("persist_ptr_literal", int'(rd), 8'hE4);

    // Address mismatch
    quietExp = 1;
    mStart();
    sendByte(8'h90);
    check("mismatch_busy", int'(busy), 0);
    sendByte(8'h01);
    sendByte(8'h55);
    mStop();
    quietExp = 0;
    checkState("mismatch");

    // Pointer wrap
    mStart();
    sendByte(8'h94);
    sendByte(8'h03);
    sendByte(8'h11);
    sendByte(8'h22);
    mStop();
    hostRead(3, rd);
    check("wrap_reg3", int'(rd), 8'h11);
    hostRead(0, rd);
    check("wrap_reg0", int'(rd), 8'h22);
    mStart();
    sendByte(8'h94);
    sendByte(8'h03);
    mStart();
    sendByte(8'h95);
    readByte(1'b1, rd);
    readByte(1'b0, rd2);
    mStop();
    check("wrap_read_first", int'(rd), 8'h11);
    check("wrap_read_second", int'(rd2), 8'h22);
    checkState("wrap");

    // Reset one cycle after the 4th data bit
    mStart();
    sendByte(8'h94);
    sendByte(8'h01);
    sendBits(8'h77, 4);
    mLow = 1'b0;
    waitCyc(1);
    reset = 1'b1;
    waitCyc(1);
    reset = 1'b0;
    modelReset();
    check("reset_mid_sda", int'(sda), 1);
    check("reset_mid_busy", int'(busy), 0);
    check("reset_mid_strobe", int'(wr_strobe), 0);
    for (int a = 0; a < 4; a++) begin
      hostRead(a, rd);
      check("reset_mid_reg", int'(rd), 0);
    end
    mStop();
    mStart();
    sendByte(8'h94);
    sendByte(8'h00);
    sendByte(8'h5A);
    mStop();
    hostRead(0, rd);
    check("after_reset_reg0", int'(rd), 8'h5A);
    checkState("after_reset");

    // STOP after 5 data bits
    mStart();
    sendByte(8'h94);
    sendByte(8'h00);
    sendBits(8'hC3, 5);
    mLow = 1'b1;
    waitCyc(Q);
    scl = 1'b1;
    waitCyc(Q);
    mLow = 1'b0;
    waitCyc(2);
    check("stop_busy_still_high", int'(busy), 1);
    waitCyc(1);
    check("stop_busy_fallen", int'(busy), 0);
    waitCyc(Q);
    mBusy = 0; mAddressed = 0; mExpAddr = 0;
    $display("STOP (after 5 bits)");
    hostRead(0, rd);
    check("partial_reg0", int'(rd), 8'h5A);
    checkState("partial");

    waitCyc(8);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
